// File: rtl/uart_tx_param_module.sv
// Parameterised UART transmitter with a transmit FIFO and back-to-back framing.
// Optional parity bit after the data bits is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_param_module #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_BITS-1:0]              tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic                              tx_pin_out,
  output logic                              tx_busy,
  output logic                              tx_done_sig,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 || FIFO_DEPTH > 256 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx_param_module: illegal parameter value");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_next;
  logic [15:0]          baud, baud_next;
  logic [3:0]           bit_idx, bit_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic                 pin_next, busy_next, done_next;
  logic                 bit_end, push, pop;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count_next;

`ifdef UART_TX_PARITY_EN
  logic par_bit, par_next;
`endif

  assign push    = tx_valid && tx_ready;
  assign bit_end = (baud == BAUD_LAST);

  always_comb begin
    state_next = state;
    baud_next  = baud + 16'd1;
    bit_next   = bit_idx;
    shreg_next = shreg;
    pin_next   = tx_pin_out;
    busy_next  = 1'b1;
    done_next  = 1'b0;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_next   = par_bit;
`endif
    case (state)
      IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        pin_next  = 1'b1;
        busy_next = 1'b0;
        if (fifo_count != '0) begin
          pop        = 1'b1;
          state_next = START;
          pin_next   = 1'b0;
          busy_next  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          baud_next  = '0;
          bit_next   = '0;
          pin_next   = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_next = '0;
          if (bit_idx == DATA_LAST) begin
            bit_next   = '0;
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
            pin_next   = par_bit;
`else
            state_next = STOP;
            pin_next   = 1'b1;
`endif
          end else begin
            bit_next   = bit_idx + 4'd1;
            shreg_next = shreg >> 1;
            pin_next   = shreg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          baud_next  = '0;
          bit_next   = '0;
          pin_next   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          baud_next = '0;
          if (bit_idx == STOP_LAST) begin
            done_next = 1'b1;
            bit_next  = '0;
            // Chain straight into the next start bit when more data is queued.
            if (fifo_count != '0) begin
              pop        = 1'b1;
              state_next = START;
              pin_next   = 1'b0;
            end else begin
              state_next = IDLE;
              pin_next   = 1'b1;
              busy_next  = 1'b0;
            end
          end else begin
            bit_next = bit_idx + 4'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = '0;
        bit_next   = '0;
        pin_next   = 1'b1;
        busy_next  = 1'b0;
      end
    endcase

    if (pop) begin
      shreg_next = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
      par_next   = (^mem[rd_ptr]) ^ 1'(PARITY_ODD);
`endif
    end
  end

  always_comb begin
    count_next = fifo_count;
    case ({push, pop})
      2'b10:   count_next = fifo_count + CW'(1);
      2'b01:   count_next = fifo_count - CW'(1);
      default: count_next = fifo_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      baud        <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      tx_pin_out  <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done_sig <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      tx_ready    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_bit     <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      baud        <= baud_next;
      bit_idx     <= bit_next;
      shreg       <= shreg_next;
      tx_pin_out  <= pin_next;
      tx_busy     <= busy_next;
      tx_done_sig <= done_next;
      fifo_count  <= count_next;
      tx_ready    <= (count_next != FULL);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
`ifdef UART_TX_PARITY_EN
      par_bit     <= par_next;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

endmodule

// File: tb/tb_uart_tx_param_module.sv
// Directed bench for uart_tx_param_module: frame shapes, FIFO full/order, stop bits, reset abort.
module tb_uart_tx_param_module;

`ifdef UART_TX_PARITY_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif
  localparam int CPB  = 4;
  localparam int RECN = 320;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       v0, v1, v2;
  logic [7:0] d0, d1;
  logic [4:0] d2;
  logic       rdy0, rdy1, rdy2, pin0, pin1, pin2;
  logic       busy0, busy1, busy2, done0, done1, done2;
  logic [2:0] cnt0, cnt1, cnt2;

  uart_tx_param_module #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1),
                         .FIFO_DEPTH(4), .PARITY_ODD(0)) u0 (
    .clk(clk), .rst(rst), .tx_data(d0), .tx_valid(v0), .tx_ready(rdy0),
    .tx_pin_out(pin0), .tx_busy(busy0), .tx_done_sig(done0), .fifo_count(cnt0));

  uart_tx_param_module #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2),
                         .FIFO_DEPTH(4), .PARITY_ODD(1)) u1 (
    .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1), .tx_ready(rdy1),
    .tx_pin_out(pin1), .tx_busy(busy1), .tx_done_sig(done1), .fifo_count(cnt1));

  uart_tx_param_module #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .STOP_BITS(1),
                         .FIFO_DEPTH(4), .PARITY_ODD(0)) u2 (
    .clk(clk), .rst(rst), .tx_data(d2), .tx_valid(v2), .tx_ready(rdy2),
    .tx_pin_out(pin2), .tx_busy(busy2), .tx_done_sig(done2), .fifo_count(cnt2));

  int         sel;
  logic       mon_pin, mon_busy, mon_done, mon_ready;
  logic [2:0] mon_count;

  always_comb begin
    mon_pin = pin0; mon_busy = busy0; mon_done = done0; mon_ready = rdy0; mon_count = cnt0;
    case (sel)
      1: begin mon_pin = pin1; mon_busy = busy1; mon_done = done1; mon_ready = rdy1; mon_count = cnt1; end
      2: begin mon_pin = pin2; mon_busy = busy2; mon_done = done2; mon_ready = rdy2; mon_count = cnt2; end
      default: ;
    endcase
  end

  int   n_vec  = 0;
  int   n_miss = 0;
  logic rec_pin  [RECN];
  logic rec_done [RECN];
  logic rec_busy [RECN];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    case (sel)
      1:       begin v1 = v; d1 = d; end
      2:       begin v2 = v; d2 = d[4:0]; end
      default: begin v0 = v; d0 = d; end
    endcase
  endtask

  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      rec_pin[i] = mon_pin; rec_done[i] = mon_done; rec_busy[i] = mon_busy;
      @(negedge clk);
    end
  endtask

  function automatic int first_low(input int n);
    for (int i = 0; i < n; i++) if (rec_pin[i] == 1'b0) return i;
    return -1;
  endfunction

  function automatic int first_done(input int s, input int n);
    for (int i = 0; i < n; i++) if (s + i < RECN && rec_done[s + i]) return i;
    return -1;
  endfunction

  function automatic int done_count(input int s, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (s + i < RECN && rec_done[s + i]) c++;
    return c;
  endfunction

  // Stretch a per-bit line sequence (bit 0 sent first) to CPB samples per bit; idle-high afterwards.
  function automatic logic [63:0] expand(input logic [15:0] seq, input int nbits);
    logic [63:0] r;
    r = '1;
    for (int b = 0; b < nbits; b++)
      for (int k = 0; k < CPB; k++) r[b * CPB + k] = seq[b];
    return r;
  endfunction

  function automatic logic [63:0] gather(input int s);
    logic [63:0] r;
    r = '1;
    for (int i = 0; i < 64; i++) if (s + i < RECN) r[i] = rec_pin[s + i];
    return r;
  endfunction

  task automatic wait_idle(input string tag);
    int t = 0;
    while (mon_busy && t < 400) begin @(negedge clk); t++; end
    if (t >= 400) check(tag, 64'(t), 64'(0));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0]  words [6];
  logic [15:0] seq;
  int          nb, s0, s, fl, t, run, lows, dones, busys;
  logic [7:0]  w;
  logic [63:0] mask, ex;

  initial begin
    words = '{8'h3C, 8'h81, 8'hF0, 8'h0F, 8'h55, 8'hC3};
    sel = 0; v0 = 0; v1 = 0; v2 = 0; d0 = '0; d1 = '0; d2 = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pin", 64'(mon_pin), 64'(1));
    check("rst_busy", 64'(mon_busy), 64'(0));
    check("rst_done", 64'(mon_done), 64'(0));
    check("rst_ready", 64'(mon_ready), 64'(1));
    check("rst_count", 64'(mon_count), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Single 0xA5 frame
    fork
      record(80);
      begin drive(1'b1, 8'hA5); @(negedge clk); drive(1'b0, 8'h00); end
    join
    s0 = first_low(80);
    check("a5_latency", 64'(s0), 64'(2));
    if (s0 < 0) s0 = 0;
    if (PE == 1) begin seq = 16'h054A; nb = 11; end
    else         begin seq = 16'h034A; nb = 10; end
    check("a5_frame", gather(s0), expand(seq, nb));
    check("a5_done_at", 64'(first_done(s0, 60)), 64'(nb * CPB));
    check("a5_done_once", 64'(done_count(0, 80)), 64'(1));
    check("a5_busy_start", 64'(rec_busy[s0]), 64'(1));
    check("a5_busy_after", 64'(rec_busy[s0 + nb * CPB]), 64'(0));
    wait_idle("a5_idle_timeout");

    // FIFO fill to depth 4, then back-to-back frames in order
    fork
      record(300);
      begin
        for (int k = 0; k < 6; k++) begin
          t = 0;
          drive(1'b1, words[k]);
          while (!mon_ready && t < 200) begin @(negedge clk); t++; end
          if (t >= 200) check("fifo_ready_timeout", 64'(t), 64'(0));
          @(negedge clk);
          if (k == 4) begin
            check("fifo_full_count", 64'(mon_count), 64'(4));
            check("fifo_full_ready", 64'(mon_ready), 64'(0));
          end
        end
        drive(1'b0, 8'h00);
      end
    join
    s0 = first_low(300);
    if (s0 < 1) begin check("fifo_start_found", 64'(s0), 64'(2)); s0 = 1; end
    fl = CPB * (10 + PE);
    for (int f = 0; f < 6; f++) begin
      s = s0 + f * fl;
      w = '0;
      for (int b = 0; b < 8; b++) w[b] = rec_pin[s + CPB * (1 + b) + 2];
      check($sformatf("fifo_word%0d", f), 64'(w), 64'(words[f]));
      if (f > 0) check($sformatf("fifo_gap%0d", f), 64'({rec_pin[s - 1], rec_pin[s]}), 64'(2'b10));
    end
    check("fifo_done_count", 64'(done_count(0, 300)), 64'(6));
    wait_idle("fifo_idle_timeout");

    // Reset in the middle of data bit 3 with two words queued
    drive(1'b1, 8'hFF); @(negedge clk);
    drive(1'b1, 8'h11); @(negedge clk);
    drive(1'b1, 8'h22);
    check("abort_started", 64'(mon_pin), 64'(0));
    @(negedge clk);
    drive(1'b0, 8'h00);
    dones = 0;
    for (int i = 0; i < 16; i++) begin
      if (mon_done) dones++;
      @(negedge clk);
    end
    check("abort_queued", 64'(mon_count), 64'(2));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_pin", 64'(mon_pin), 64'(1));
    check("abort_count", 64'(mon_count), 64'(0));
    check("abort_busy", 64'(mon_busy), 64'(0));
    lows = 0; busys = 0;
    for (int i = 0; i < 60; i++) begin
      if (mon_done) dones++;
      if (!mon_pin) lows++;
      if (mon_busy) busys++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(dones), 64'(0));
    check("abort_line_quiet", 64'(lows + busys), 64'(0));

    // Two stop bits: 0x00 followed by another 0x00
    sel = 1;
    @(negedge clk);
    fork
      record(80);
      begin
        drive(1'b1, 8'h00); @(negedge clk);
        drive(1'b1, 8'h00); @(negedge clk);
        drive(1'b0, 8'h00);
      end
    join
    s0 = first_low(80);
    check("stop2_latency", 64'(s0), 64'(2));
    if (s0 < 0) s0 = 0;
    if (PE == 1) begin seq = 16'h0E00; nb = 12; end
    else         begin seq = 16'h0600; nb = 11; end
    mask = (64'd1 << (nb * CPB + CPB)) - 64'd1;
    ex = expand(seq, nb);
    for (int k = 0; k < CPB; k++) ex[nb * CPB + k] = 1'b0;
    check("stop2_frame", gather(s0) & mask, ex & mask);
    run = 0;
    for (int i = s0 + nb * CPB - 1; i >= s0 && rec_pin[i]; i--) run++;
    check("stop2_high_run", 64'(run), 64'(2 * CPB + PE * CPB));
    check("stop2_done_at", 64'(first_done(s0, 60)), 64'(nb * CPB));
    wait_idle("stop2_idle_timeout");

    // Five data bits: 0x1F
    sel = 2;
    @(negedge clk);
    fork
      record(80);
      begin drive(1'b1, 8'h1F); @(negedge clk); drive(1'b0, 8'h00); end
    join
    s0 = first_low(80);
    check("db5_latency", 64'(s0), 64'(2));
    if (s0 < 0) s0 = 0;
    if (PE == 1) begin seq = 16'h00FE; nb = 8; end
    else         begin seq = 16'h007E; nb = 7; end
    check("db5_frame", gather(s0), expand(seq, nb));
    check("db5_done_at", 64'(first_done(s0, 60)), 64'(nb * CPB));
    check("db5_done_once", 64'(done_count(0, 80)), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
